// File: rtl/jk_seq_driver_pkg.sv
// Shared types for the JK sequence driver: controller state encoding and the
// J/K excitation codes presented to each external flop.
package jk_seq_driver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Toggle is deliberately never produced: every transition is an explicit set or reset.
    function automatic logic [1:0] jk_code(input logic cur_bit, input logic nxt_bit);
        case ({cur_bit, nxt_bit})
            2'b01:   return JK_SET;
            2'b10:   return JK_RST;
            default: return JK_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/jk_seq_driver_if.sv
// Target handshake plus JK bank drive/feedback bundle between the driver and its user.
interface jk_seq_driver_if #(
    parameter int WIDTH = 4
);
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;
    logic             dir;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output tgt_valid, tgt_data, dir, q_fb,
        input  tgt_ready, j, k, busy, done, err
    );

    modport slave (
        input  tgt_valid, tgt_data, dir, q_fb,
        output tgt_ready, j, k, busy, done, err
    );
endinterface

// File: rtl/jk_seq_driver_jk_excite.sv
// Per-bit JK excitation: J/K values that move one flop from cur_bit to nxt_bit.
module jk_excite
    import jk_seq_driver_pkg::*;
(
    input  logic cur_bit,
    input  logic nxt_bit,
    output logic j,
    output logic k
);
    logic [1:0] code;

    assign code = jk_code(cur_bit, nxt_bit);
    assign j    = code[1];
    assign k    = code[0];
endmodule

// File: rtl/jk_seq_driver.sv
// Steps an external JK flop bank one count at a time toward a requested value,
// verifying the fed-back bank state after every step.
module jk_seq_driver
    import jk_seq_driver_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    jk_seq_driver_if.slave  bus
);
    state_t           state_reg, state_next;
    logic [WIDTH-1:0] cur_reg, cur_next;
    logic [WIDTH-1:0] nxt_reg, nxt_next;
    logic [WIDTH-1:0] tgt_reg, tgt_next;
    logic             dir_reg, dir_next;
    logic             err_reg, err_next;
    logic [WIDTH-1:0] j_reg, j_next;
    logic [WIDTH-1:0] k_reg, k_next;
    logic [WIDTH-1:0] exc_j, exc_k;

    function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] v, input logic d);
        return d ? v - WIDTH'(1) : v + WIDTH'(1);
    endfunction

    // Excitation is computed from the upcoming cur/nxt so j/k can be registered
    // and valid for the whole DRIVE cycle.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_excite
            jk_excite u_excite (
                .cur_bit (cur_next[gi]),
                .nxt_bit (nxt_next[gi]),
                .j       (exc_j[gi]),
                .k       (exc_k[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cur_reg   <= '0;
            nxt_reg   <= '0;
            tgt_reg   <= '0;
            dir_reg   <= 1'b0;
            err_reg   <= 1'b0;
            j_reg     <= '0;
            k_reg     <= '0;
        end else begin
            state_reg <= state_next;
            cur_reg   <= cur_next;
            nxt_reg   <= nxt_next;
            tgt_reg   <= tgt_next;
            dir_reg   <= dir_next;
            err_reg   <= err_next;
            j_reg     <= j_next;
            k_reg     <= k_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cur_next   = cur_reg;
        nxt_next   = nxt_reg;
        tgt_next   = tgt_reg;
        dir_next   = dir_reg;
        err_next   = err_reg;
        case (state_reg)
            ST_IDLE, ST_ERR: begin
                if (bus.tgt_valid) begin
                    tgt_next = bus.tgt_data;
                    dir_next = bus.dir;
                    cur_next = bus.q_fb;
                    err_next = 1'b0;
                    if (bus.q_fb == bus.tgt_data) begin
                        state_next = ST_DONE;
                    end else begin
                        nxt_next   = step_val(bus.q_fb, bus.dir);
                        state_next = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: state_next = ST_CHECK;
            ST_CHECK: begin
                if (bus.q_fb == nxt_reg) begin
                    cur_next = nxt_reg;
                    if (nxt_reg == tgt_reg) begin
                        state_next = ST_DONE;
                    end else begin
                        nxt_next   = step_val(nxt_reg, dir_reg);
                        state_next = ST_DRIVE;
                    end
                end else begin
                    state_next = ST_ERR;
                    err_next   = 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        j_next = (state_next == ST_DRIVE) ? exc_j : '0;
        k_next = (state_next == ST_DRIVE) ? exc_k : '0;
    end

    assign bus.tgt_ready = (state_reg == ST_IDLE) || (state_reg == ST_ERR);
    assign bus.busy      = (state_reg == ST_DRIVE) || (state_reg == ST_CHECK);
    assign bus.done      = (state_reg == ST_DONE);
    assign bus.err       = err_reg;
    assign bus.j         = j_reg;
    assign bus.k         = k_reg;

endmodule

// File: doc/jk_seq_driver.md
JK_SEQ_DRIVER -- requirements
Module: jk_seq_driver

Interface
REQ-001 Parameter WIDTH, default 4: width of the external JK flip-flop bank driven by this block.
REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 tgt_valid  input  1  target request valid.
REQ-005 tgt_data  input  WIDTH  target count value.
REQ-006 dir  input  1  count direction, sampled with the target: 0 = up, 1 = down.
REQ-007 tgt_ready  output  1  block can accept a target.
REQ-008 q_fb  input  WIDTH  q outputs of the external JK bank, fed back to this block.
REQ-009 j  output  WIDTH  registered J drive, one bit per external flop.
REQ-010 k  output  WIDTH  registered K drive, one bit per external flop.
REQ-011 busy  output  1  stepping in progress.
REQ-012 done  output  1  one-cycle pulse when the bank reaches the target.
REQ-013 err  output  1  feedback mismatch detected; sticky until the next accept.

Function
REQ-014 States SHALL be IDLE, DRIVE, CHECK, DONE and ERR.
REQ-015 A target is accepted when tgt_valid and tgt_ready are both 1; tgt_ready SHALL be 1 only in IDLE and ERR.
REQ-016 On accept: latch tgt_data and dir, load cur from q_fb, clear err, and go to CHECK-equivalent compare (see REQ-017).
REQ-017 On accept, if q_fb equals tgt_data, go to DONE; otherwise compute nxt and go to DRIVE.
REQ-018 nxt = cur+1 (dir=0) or cur-1 (dir=1), modulo 2^WIDTH; wrap-around is permitted (F->0 up, 0->F down).
REQ-019 In DRIVE, per bit (cur->nxt), j/k SHALL be: 0->0 = 00; 0->1 = 10; 1->0 = 01; 1->1 = 00. Code 11 (toggle) SHALL never be driven.
REQ-020 DRIVE lasts exactly one cycle; the external bank captures j/k at the closing edge.
REQ-021 In CHECK, j/k SHALL be 00 and q_fb is compared with nxt.
REQ-022 On a CHECK match, cur<=nxt; if nxt equals the target go to DONE, else compute the new nxt and go to DRIVE. Each step therefore takes 2 cycles.
REQ-023 On a CHECK mismatch, go to ERR and set err=1; j/k stay 00.
REQ-024 DONE lasts one cycle with done=1, then returns to IDLE.
REQ-025 busy SHALL be 1 in DRIVE and CHECK, and 0 otherwise.
REQ-026 Outside DRIVE, j and k SHALL be all-zero.
REQ-027 tgt_valid is ignored while busy or in DONE; no queuing.

Reset
REQ-028 Asserting reset (low) SHALL immediately force IDLE with j=0, k=0, tgt_ready=1, busy=0, done=0, err=0, cur=0, and the target register=0.
REQ-029 A reset during DRIVE/CHECK SHALL abandon the operation; the external bank state is not restored.
REQ-030 After reset is released, the first accept SHALL resynchronise from q_fb.

Structure
REQ-031 The shared package SHALL hold the state encoding and the JK code constants (HOLD=00, RST=01, SET=10, TGL=11).
REQ-032 Per-bit excitation SHALL live in a sub-module jk_excite (inputs cur_bit, nxt_bit; outputs j, k), instantiated WIDTH times.

Verification
The bench models the external bank as WIDTH behavioural JK flops clocked by clock with q fed to q_fb; WIDTH=4.
REQ-033 Bank=3, target 6, dir=0 -> j/k steps 3->4->5->6; done pulses 6 cycles after accept; q_fb=6; err=0.
REQ-034 Bank=1, target E, dir=1 -> wraps 1->0->F->E; j=0000/k=0001 drives the first step; done after 6 cycles.
REQ-035 Bank=9, target 9 -> done asserts the cycle after accept; j/k never leave 0000.
REQ-036 Bank=2, target 5, dir=0, bench forces q_fb bit0 stuck-at-0 -> the first CHECK mismatches; ERR, err=1, tgt_ready=1. A new target 2 clears err and completes.
REQ-037 Reset pulsed in the CHECK of the second step for target A from 0 -> all outputs are at reset values immediately, tgt_ready=1; a new accept proceeds from the current q_fb.
REQ-038 tgt_valid held high throughout a run with a changing tgt_data -> only the first value is acted on; the next accept occurs in IDLE after done.
